instr_unpacker: RTL and testbench
=================================

INSTR_UNPACKER -- requirements
Module: instr_unpacker

Interface
REQ-001 The parameter NUM_ARGS SHALL default to 4 and set the number of argument slots, legal range 1..4.
REQ-002 The parameter REG_W SHALL default to 6 and set the register-index width per slot, with NUM_ARGS*REG_W <= 24.
REQ-003 The parameter OPCODE_COUNT SHALL default to 91 and set the number of legal opcode_t values.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  synchronous discard of any partial or held instruction.
REQ-007 in_valid / in_ready / in_data  in / out / in  1 / 1 / 64  fetch word stream, valid/ready handshake.
REQ-008 out_valid / out_ready  out / in  1 / 1  decoded-instruction handshake.
REQ-009 out_opcode  out  16  opcode_t value.
REQ-010 out_size  out  4*NUM_ARGS  sizeFlags_t per slot; slot i at [4i+3:4i].
REQ-011 out_flags  out  8  flags_t.
REQ-012 out_arg  out  64*NUM_ARGS  slot i at [64i+63:64i]: immediate value, or zero-extended register index.
REQ-013 out_imm  out  NUM_ARGS  bit i set when slot i carries an immediate.
REQ-014 out_err_op / out_err_size  out  1 / 1  opcode >= OPCODE_COUNT / illegal size code on an immediate slot.

Function
REQ-015 Header word layout SHALL be: [15:0] opcode; [16+4i+3:16+4i] size of slot i; [39:32] flags; [40+REG_W*i+REG_W-1:40+REG_W*i] register index of slot i; all other bits ignored.
REQ-016 Flag bit i (i < NUM_ARGS) SHALL mark slot i as immediate; exactly one extra 64-bit word per immediate slot SHALL follow the header, in ascending slot order.
REQ-017 FSM states SHALL be HDR, ARG, OUT; the reset state is HDR.
REQ-018 HDR: in_ready=1; on handshake, latch the header fields; go to ARG when the immediate mask is non-zero, else to OUT.
REQ-019 ARG: in_ready=1; each handshake fills the lowest unfilled immediate slot; after the last one, go to OUT.
REQ-020 OUT: in_ready=0, out_valid=1, and all out_* fields held stable; on out_ready, go to HDR.
REQ-021 Minimum latency SHALL be one cycle from header handshake to out_valid with no immediates, and one cycle from the last immediate word handshake otherwise.
REQ-022 Immediates SHALL be masked to their size: code 0 keeps 8 bits, 1 keeps 16, 2 keeps 32, 3 keeps 64, and the upper bits are zero.
REQ-023 A size code > 3 on an immediate slot SHALL set out_err_size and pass the full 64 bits; size codes on register slots SHALL be passed through unchecked.
REQ-024 out_err_op and out_err_size SHALL be informational only; the instruction is still emitted.
REQ-025 Header bits for slots >= NUM_ARGS SHALL be ignored.
REQ-026 flush SHALL take priority over every handshake in the same cycle: go to HDR, clear out_valid, and not consume in_data that cycle.
REQ-027 Holding in_valid low in ARG SHALL stall with no timeout.

Reset
REQ-028 Asserting rst_n low SHALL immediately force state HDR, out_valid=0, and every out_* field to zero.
REQ-029 A reset during ARG or OUT SHALL abandon the partial or held instruction with no output.
REQ-030 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after its release.

Configuration
REQ-031 With SIGN_EXTEND_EN defined, flag bit 4+i set on immediate slot i SHALL sign-extend the masked value from its size to 64 bits.
REQ-032 Without SIGN_EXTEND_EN, flag bits 4..7 SHALL have no effect on slot values and immediates are always zero-extended.

Verification
REQ-033 Header 0x0000_0000_0000_0008 (ADD, all sizes 0, flags 0) -> out_valid one cycle later, out_imm=0, all args 0, out_err_op=0.
REQ-034 Header with flags=0x05, sizes 0/1/2/3, then words 0xFFFF_FFFF_FFFF_FF80 and 0x1234_5678_9ABC_DEF0 -> arg0=0x80, arg2=0x9ABC_DEF0, out_imm=0b0101.
REQ-035 Same header with flags=0x15 under SIGN_EXTEND_EN -> arg0=0xFFFF_FFFF_FFFF_FF80; without the macro -> arg0=0x80.
REQ-036 Opcode 0x005B with size code 5 on an immediate slot -> out_err_op=1 and out_err_size=1, instruction still emitted.
REQ-037 Hold out_ready low for 5 cycles in OUT -> in_ready=0 and outputs stable; flush asserted with in_valid=1 -> no word consumed, out_valid=0 next cycle.
REQ-038 Drop rst_n mid-ARG after 1 of 3 immediates -> out_valid stays 0; after release, a new header decodes correctly.

Source files
------------

// File: rtl/instr_unpacker.sv
// ---------------------------------------------------------------------------
// instr_unpacker
//   Turns a stream of 64-bit fetch words into decoded instructions. Each
//   instruction is one header word. One extra 64-bit word follows for each
//   argument slot that is marked immediate, in ascending slot order.
//
//   Header layout:
//     [15:0]                    opcode
//     [16+4i +: 4]              size code of slot i
//     [39:32]                   flags (bit i = slot i is immediate,
//                                      bit 4+i = sign-extend slot i)
//     [40+REG_W*i +: REG_W]     register index of slot i
//
// Optional feature macro: SIGN_EXTEND_EN
//   When defined, flag bit 4+i sign-extends immediate slot i from its size.
//   When undefined, immediates are always zero-extended.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous discard of any partial or held instruction
//   in_valid/in_ready fetch word handshake, in_data = 64-bit word
//   out_valid/out_ready decoded instruction handshake
//   out_opcode        opcode
//   out_size          size code per slot, slot i at [4i+3:4i]
//   out_flags         flags byte
//   out_arg           slot i at [64i+63:64i]: masked immediate or register index
//   out_imm           bit i set when slot i carries an immediate
//   out_err_op        opcode >= OPCODE_COUNT (informational only)
//   out_err_size      size code > 3 on an immediate slot (informational only)
// ---------------------------------------------------------------------------
module instr_unpacker #(
  parameter int NUM_ARGS     = 4,
  parameter int REG_W        = 6,
  parameter int OPCODE_COUNT = 91
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_opcode,
  output logic [4*NUM_ARGS-1:0] out_size,
  output logic [7:0]            out_flags,
  output logic [64*NUM_ARGS-1:0] out_arg,
  output logic [NUM_ARGS-1:0]   out_imm,
  output logic                  out_err_op,
  output logic                  out_err_size
);

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_ARG = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [15:0]             r_opcode;
  logic [4*NUM_ARGS-1:0]   r_size;
  logic [7:0]              r_flags;
  logic [64*NUM_ARGS-1:0]  r_arg;
  logic [NUM_ARGS-1:0]     r_imm;
  logic [NUM_ARGS-1:0]     r_pending;   // immediate slots still waiting for a word
  logic                    r_err_op;
  logic                    r_err_size;

  logic                    w_hdr_hs;
  logic                    w_arg_hs;
  logic [NUM_ARGS-1:0]     w_sel;       // one-hot: lowest unfilled immediate slot
  logic [NUM_ARGS-1:0]     w_rest;      // pending slots after this fill
  logic [NUM_ARGS-1:0]     w_sext;
  logic                    w_hdr_err_size;
  logic                    w_hdr_err_op;

  // Mask an immediate to its size; optionally sign-extend from the top kept bit.
  // Codes above 3 pass all 64 bits unchanged.
  function automatic logic [63:0] f_mask_imm(input logic [63:0] d,
                                             input logic [3:0]  code,
                                             input logic        sext);
    logic [63:0] v;
    v = d;
    case (code)
      4'd0:    v = sext ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      4'd1:    v = sext ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      4'd2:    v = sext ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      4'd3:    v = d;
      default: v = d;
    endcase
    return v;
  endfunction

  // Handshakes never fire in a flush cycle, so flush never consumes a word.
  assign w_hdr_hs = (r_state == S_HDR) && in_valid && !flush;
  assign w_arg_hs = (r_state == S_ARG) && in_valid && !flush;

  assign w_sel  = r_pending & ((~r_pending) + NUM_ARGS'(1));
  assign w_rest = r_pending & ~w_sel;

`ifdef SIGN_EXTEND_EN
  assign w_sext = r_flags[4 +: NUM_ARGS];
`else
  assign w_sext = {NUM_ARGS{1'b0}};
`endif

  assign w_hdr_err_op = (in_data[15:0] >= 16'(OPCODE_COUNT));

  // Size check on the incoming header: any immediate slot with code > 3.
  always_comb begin
    w_hdr_err_size = 1'b0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      w_hdr_err_size = w_hdr_err_size |
                       (in_data[32+i] & (in_data[16+4*i +: 4] > 4'd3));
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_HDR;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_hdr_hs) begin
            w_state_next = (|in_data[32 +: NUM_ARGS]) ? S_ARG : S_OUT;
          end else begin
            w_state_next = S_HDR;
          end
        end
        S_ARG: begin
          if (w_arg_hs && (w_rest == {NUM_ARGS{1'b0}})) begin
            w_state_next = S_OUT;
          end else begin
            w_state_next = S_ARG;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            w_state_next = S_HDR;
          end else begin
            w_state_next = S_OUT;
          end
        end
        default: w_state_next = S_HDR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Instruction field registers: latched from the header, filled by immediates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode   <= 16'd0;
      r_size     <= {(4*NUM_ARGS){1'b0}};
      r_flags    <= 8'd0;
      r_arg      <= {(64*NUM_ARGS){1'b0}};
      r_imm      <= {NUM_ARGS{1'b0}};
      r_pending  <= {NUM_ARGS{1'b0}};
      r_err_op   <= 1'b0;
      r_err_size <= 1'b0;
    end else if (w_hdr_hs) begin
      r_opcode   <= in_data[15:0];
      r_size     <= in_data[16 +: 4*NUM_ARGS];
      r_flags    <= in_data[39:32];
      r_imm      <= in_data[32 +: NUM_ARGS];
      r_pending  <= in_data[32 +: NUM_ARGS];
      r_err_op   <= w_hdr_err_op;
      r_err_size <= w_hdr_err_size;
      // Register slots get their index now; immediate slots start at zero.
      for (int i = 0; i < NUM_ARGS; i++) begin
        r_arg[64*i +: 64] <= in_data[32+i] ? 64'd0 :
                             {{(64-REG_W){1'b0}}, in_data[40+REG_W*i +: REG_W]};
      end
    end else if (w_arg_hs) begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (w_sel[i]) begin
          r_arg[64*i +: 64] <= f_mask_imm(in_data, r_size[4*i +: 4], w_sext[i]);
        end
      end
      r_pending <= w_rest;
    end
  end

  // in_ready is forced low while reset is held.
  assign in_ready     = rst_n && (r_state != S_OUT);
  assign out_valid    = (r_state == S_OUT);
  assign out_opcode   = r_opcode;
  assign out_size     = r_size;
  assign out_flags    = r_flags;
  assign out_arg      = r_arg;
  assign out_imm      = r_imm;
  assign out_err_op   = r_err_op;
  assign out_err_size = r_err_size;

endmodule

// File: tb/tb_instr_unpacker.sv
module tb_instr_unpacker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_opcode;
  logic [15:0]  out_size;
  logic [7:0]   out_flags;
  logic [255:0] out_arg;
  logic [3:0]   out_imm;
  logic         out_err_op;
  logic         out_err_size;

  int total = 0;
  int bad   = 0;

  instr_unpacker dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_size(out_size), .out_flags(out_flags),
    .out_arg(out_arg), .out_imm(out_imm),
    .out_err_op(out_err_op), .out_err_size(out_err_size)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  opcode;
    logic [15:0]  size;
    logic [7:0]   flags;
    logic [255:0] arg;
    logic [3:0]   imm;
    logic         eo;
    logic         es;
  } exp_t;

  typedef struct {
    logic [63:0]  hdr;
    logic [255:0] words;   // word k at [64k +: 64]
    logic [255:0] arg;
    logic [3:0]   imm;
    logic         eo;
    logic         es;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [63:0] mk_hdr(input logic [15:0] op, input logic [15:0] sizes,
                                         input logic [7:0] flags, input logic [23:0] regs);
    return {regs, flags, sizes, op};
  endfunction

  // Reference model: decode straight from the header rules.
  function automatic exp_t model(input logic [63:0] h, input logic [255:0] w);
    exp_t e;
    int k;
    int bits;
    logic [63:0] v, m;
    logic [3:0] sz;
    e.opcode = h[15:0];
    e.size   = h[31:16];
    e.flags  = h[39:32];
    e.imm    = h[35:32];
    e.eo     = (h[15:0] >= 16'd91);
    e.es     = 1'b0;
    e.arg    = '0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      sz = h[16+4*i +: 4];
      if (h[32+i]) begin
        v = w[64*k +: 64];
        k++;
        if (sz > 4'd3) begin
          e.es = 1'b1;
        end else begin
          bits = 8 << sz;
          m = (bits == 64) ? {64{1'b1}} : ((64'd1 << bits) - 64'd1);
          v = v & m;
`ifdef SIGN_EXTEND_EN
          if (h[36+i] && bits < 64 && v[bits-1]) v = v | ~m;
`endif
        end
      end else begin
        v = 64'(h[40+6*i +: 6]);
      end
      e.arg[64*i +: 64] = v;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic push(input logic [63:0] w, input int gap);
    int n;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("push_timeout", 256'd0, 256'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "/opcode"}, out_opcode, e.opcode);
    chk({tag, "/size"},   out_size,   e.size);
    chk({tag, "/flags"},  out_flags,  e.flags);
    chk({tag, "/arg"},    out_arg,    e.arg);
    chk({tag, "/imm"},    out_imm,    e.imm);
    chk({tag, "/err_op"}, out_err_op, e.eo);
    chk({tag, "/err_sz"}, out_err_size, e.es);
  endtask

  // Send a complete instruction, check one-cycle latency and fields,
  // hold out_ready low for 'hold' cycles, then retire it.
  task automatic run_instr(input string tag, input logic [63:0] h, input logic [255:0] w,
                           input exp_t e, input int hold, input int gap);
    int n;
    n = $countones(h[35:32]);
    push(h, gap);
    for (int k = 0; k < n; k++) push(w[64*k +: 64], gap);
    chk({tag, "/latency"}, out_valid, 1'b1);
    check_out(tag, e);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk({tag, "/hold_valid"}, out_valid, 1'b1);
      chk({tag, "/hold_ready"}, in_ready, 1'b0);
      chk({tag, "/hold_arg"},   out_arg, e.arg);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/retired"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [63:0]  h;
    logic [255:0] w;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;

    // Directed vectors with hand-derived expectations.
    tbl[0] = '{mk_hdr(16'h0008, 16'h0000, 8'h00, 24'h0), 256'd0, 256'd0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{mk_hdr(16'h0008, 16'h3210, 8'h05, 24'h0),
               {128'd0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FF80},
               {64'h0, 64'h9ABC_DEF0, 64'h0, 64'h80}, 4'b0101, 1'b0, 1'b0};
    tbl[2] = '{mk_hdr(16'h0008, 16'h3210, 8'h15, 24'h0),
               {128'd0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FF80},
`ifdef SIGN_EXTEND_EN
               {64'h0, 64'h9ABC_DEF0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80},
`else
               {64'h0, 64'h9ABC_DEF0, 64'h0, 64'h80},
`endif
               4'b0101, 1'b0, 1'b0};
    tbl[3] = '{mk_hdr(16'h005B, 16'h0075, 8'h01, 24'h0),
               {192'd0, 64'hDEAD_BEEF_0123_4567},
               {192'd0, 64'hDEAD_BEEF_0123_4567}, 4'b0001, 1'b1, 1'b1};
    tbl[4] = '{mk_hdr(16'h005A, 16'h1111, 8'hF0, {6'h3F, 6'h15, 6'h2A, 6'h01}), 256'd0,
               {64'h3F, 64'h15, 64'h2A, 64'h01}, 4'b0000, 1'b0, 1'b0};
    tbl[5] = '{mk_hdr(16'h0001, 16'h1203, 8'h0F, 24'hFFFFFF),
               {64'h0000_0000_0001_8765, 64'hFFFF_FFFF_8000_0001,
                64'h1234_5678_9ABC_DEFF, 64'hAAAA_BBBB_CCCC_DDDD},
               {64'h8765, 64'h8000_0001, 64'hFF, 64'hAAAA_BBBB_CCCC_DDDD}, 4'b1111, 1'b0, 1'b0};

    // Reset state.
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_arg", out_arg, 256'd0);
    chk("rst_opcode", out_opcode, 16'd0);
    #19 rst_n = 1'b1;
    #1 chk("rst_release_ready", in_ready, 1'b1);
    tick();

    for (int t = 0; t < 6; t++) begin
      e.opcode = tbl[t].hdr[15:0];
      e.size   = tbl[t].hdr[31:16];
      e.flags  = tbl[t].hdr[39:32];
      e.arg    = tbl[t].arg;
      e.imm    = tbl[t].imm;
      e.eo     = tbl[t].eo;
      e.es     = tbl[t].es;
      run_instr($sformatf("vec%0d", t), tbl[t].hdr, tbl[t].words, e, 0, 0);
    end

    // Hold in OUT for 5 cycles, then flush with in_valid high.
    h = mk_hdr(16'h0010, 16'h0000, 8'h00, 24'h000041);
    e = model(h, 256'd0);
    push(h, 0);
    chk("hold/latency", out_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold/ready", in_ready, 1'b0);
      chk("hold/valid", out_valid, 1'b1);
      chk("hold/arg", out_arg, e.arg);
      chk("hold/opcode", out_opcode, e.opcode);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = mk_hdr(16'h0003, 16'h0, 8'h00, 24'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out/valid", out_valid, 1'b0);
    chk("flush_out/ready", in_ready, 1'b1);

    // Flush in HDR must not consume the presented header.
    flush = 1'b1; in_valid = 1'b1; in_data = mk_hdr(16'h0003, 16'h0, 8'h00, 24'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_hdr/noconsume", out_valid, 1'b0);
    tick();
    chk("flush_hdr/still_idle", out_valid, 1'b0);

    // Flush mid-ARG, then a fresh instruction decodes normally.
    push(mk_hdr(16'h0004, 16'h0000, 8'h03, 24'h0), 0);
    push(64'h55, 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'h66;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_arg/valid", out_valid, 1'b0);
    h = mk_hdr(16'h0007, 16'h0000, 8'h00, 24'h00_0FC0);
    run_instr("after_flush", h, 256'd0, model(h, 256'd0), 0, 0);

    // Stall in ARG with in_valid low.
    h = mk_hdr(16'h0020, 16'h0001, 8'h01, 24'h0);
    w = {192'd0, 64'h0000_0000_0000_BEEF};
    push(h, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall/valid", out_valid, 1'b0);
    end
    push(w[63:0], 0);
    chk("stall/latency", out_valid, 1'b1);
    check_out("stall", model(h, w));
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset mid-ARG after 1 of 3 immediates.
    push(mk_hdr(16'h0030, 16'h0000, 8'h07, 24'h0), 0);
    push(64'h11, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_arg/valid", out_valid, 1'b0);
    chk("rst_arg/ready", in_ready, 1'b0);
    chk("rst_arg/arg", out_arg, 256'd0);
    chk("rst_arg/imm", out_imm, 4'd0);
    tick();
    chk("rst_arg/held_valid", out_valid, 1'b0);
    #3 rst_n = 1'b1;
    #1 chk("rst_arg/release_ready", in_ready, 1'b1);
    tick();
    chk("rst_arg/no_output", out_valid, 1'b0);
    h = mk_hdr(16'h0008, 16'h0002, 8'h01, 24'h0);
    w = {192'd0, 64'hFFFF_0000_1234_5678};
    run_instr("after_rst", h, w, model(h, w), 1, 0);

    // Randomized instructions against the model.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] sizes;
      for (int i = 0; i < 4; i++) begin
        sizes[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                      : 4'($urandom_range(0, 3));
      end
      h = mk_hdr(16'($urandom_range(0, 100)), sizes, 8'($urandom), 24'($urandom));
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_instr($sformatf("rnd%0d", r), h, w, model(h, w),
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
